// File: rtl/pellet_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pellet_ctrl                                                  |
// | Description : Per-frame pellet scan against the player; owns pellet        |
// |               alive flags, drawer coordinates, score and level-clear.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pellet_ctrl #(
    parameter int N_DOTS     = 15,
    parameter int HIT_R      = 8,
    parameter int DOT_POINTS = 10,
    parameter int SCORE_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vblnk,
    input  logic [10:0]                    player_x,
    input  logic [10:0]                    player_y,
    input  logic                           game_start,
    output logic [N_DOTS-1:0][31:0]        position_x,
    output logic [N_DOTS-1:0][31:0]        position_y,
    output logic [N_DOTS-1:0]              dot_alive,
    output logic [SCORE_W-1:0]             score,
    output logic                           all_eaten,
    output logic                           scan_busy
);

    localparam int IDX_W = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(N_DOTS - 1);
    localparam logic [11:0]        c_dot_y    = 12'd30;
    localparam logic [11:0]        c_hit_r    = 12'(HIT_R);
    localparam logic [SCORE_W:0]   c_pts      = (SCORE_W + 1)'(DOT_POINTS);

    typedef enum logic [1:0] {
        WAIT_VB = 2'd0,
        SCAN    = 2'd1,
        OVER    = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_vblnk_q;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [10:0]          r_px, r_py, w_px_nxt, w_py_nxt;
    logic [N_DOTS-1:0]    r_alive, w_alive_nxt;
    logic [SCORE_W-1:0]   r_score, w_score_nxt;
    logic                 r_all_eaten, w_all_eaten_nxt;
    logic                 r_busy, w_busy_nxt;

    logic                 w_vb_rise;
    logic [11:0]          w_dot_x, w_px12, w_py12, w_dx, w_dy;
    logic                 w_hit;
    logic [SCORE_W:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_inc;

    function automatic logic [31:0] table_x(input int k);
        return 32'(32 + 64 * k);
    endfunction

    assign w_vb_rise = vblnk & ~r_vblnk_q;

    // Chebyshev distance from the latched player centre to the pellet under scan
    assign w_dot_x = 12'(32 + 64 * int'(r_idx));
    assign w_px12  = {1'b0, r_px};
    assign w_py12  = {1'b0, r_py};
    assign w_dx    = (w_px12 >= w_dot_x) ? (w_px12 - w_dot_x) : (w_dot_x - w_px12);
    assign w_dy    = (w_py12 >= c_dot_y) ? (w_py12 - c_dot_y) : (c_dot_y - w_py12);
    assign w_hit   = (w_dx <= c_hit_r) && (w_dy <= c_hit_r);

    assign w_sum       = {1'b0, r_score} + c_pts;
    assign w_score_inc = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_px_nxt        = r_px;
        w_py_nxt        = r_py;
        w_alive_nxt     = r_alive;
        w_score_nxt     = r_score;
        w_all_eaten_nxt = r_all_eaten;
        w_busy_nxt      = r_busy;

        if (game_start) begin
            w_state_nxt     = WAIT_VB;
            w_idx_nxt       = '0;
            w_alive_nxt     = '1;
            w_score_nxt     = '0;
            w_all_eaten_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
        end else begin
            case (r_state)
                WAIT_VB: begin
                    if (w_vb_rise) begin
                        w_state_nxt = SCAN;
                        w_idx_nxt   = '0;
                        w_px_nxt    = player_x;
                        w_py_nxt    = player_y;
                        w_busy_nxt  = 1'b1;
                    end
                end
                SCAN: begin
                    if (r_alive[r_idx] && w_hit) begin
                        w_alive_nxt[r_idx] = 1'b0;
                        w_score_nxt        = w_score_inc;
                    end
                    if (r_idx == c_last_idx) begin
                        w_busy_nxt = 1'b0;
                        // The pellet cleared on this very edge counts toward level clear
                        if (w_alive_nxt == '0) begin
                            w_state_nxt     = OVER;
                            w_all_eaten_nxt = 1'b1;
                        end else begin
                            w_state_nxt = WAIT_VB;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
                OVER: begin
                end
                default: begin
                    w_state_nxt = WAIT_VB;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= WAIT_VB;
            r_vblnk_q   <= 1'b1;
            r_idx       <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_alive     <= '1;
            r_score     <= '0;
            r_all_eaten <= 1'b0;
            r_busy      <= 1'b0;
            for (int k = 0; k < N_DOTS; k++) begin
                position_x[k] <= table_x(k);
                position_y[k] <= 32'd30;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_vblnk_q   <= vblnk;
            r_idx       <= w_idx_nxt;
            r_px        <= w_px_nxt;
            r_py        <= w_py_nxt;
            r_alive     <= w_alive_nxt;
            r_score     <= w_score_nxt;
            r_all_eaten <= w_all_eaten_nxt;
            r_busy      <= w_busy_nxt;
            // Coordinates follow the next alive state so they vanish on the clearing edge
            for (int k = 0; k < N_DOTS; k++) begin
                position_x[k] <= w_alive_nxt[k] ? table_x(k) : 32'd0;
                position_y[k] <= w_alive_nxt[k] ? 32'd30     : 32'd0;
            end
        end
    end

    assign dot_alive = r_alive;
    assign score     = r_score;
    assign all_eaten = r_all_eaten;
    assign scan_busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pellet_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pellet_ctrl                                               |
// | Description : Scoreboard bench for pellet_ctrl frame scans.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pellet_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               vblnk = 1'b1;
    logic [10:0]        player_x = '0;
    logic [10:0]        player_y = '0;
    logic               game_start = 1'b0;
    logic [14:0][31:0]  pos_x, pos_y, s_pos_x, s_pos_y;
    logic [14:0]        dot_alive, s_alive;
    logic [15:0]        score;
    logic [4:0]         s_score;
    logic               all_eaten, scan_busy, s_all_eaten, s_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [14:0] alive;
        logic [14:0] hits;
        int          score;
        logic        all_eaten;
    } exp_t;

    exp_t        sb[$];
    logic [14:0] m_alive;
    int          m_score;
    logic        m_over;

    always #5 clk = ~clk;

    pellet_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblnk      (vblnk),
        .player_x   (player_x),
        .player_y   (player_y),
        .game_start (game_start),
        .position_x (pos_x),
        .position_y (pos_y),
        .dot_alive  (dot_alive),
        .score      (score),
        .all_eaten  (all_eaten),
        .scan_busy  (scan_busy)
    );

    // Narrow score counter to reach saturation within one level
    pellet_ctrl #(.SCORE_W(5)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblnk      (vblnk),
        .player_x   (player_x),
        .player_y   (player_y),
        .game_start (game_start),
        .position_x (s_pos_x),
        .position_y (s_pos_y),
        .dot_alive  (s_alive),
        .score      (s_score),
        .all_eaten  (s_all_eaten),
        .scan_busy  (s_busy)
    );

    task automatic chk(input string tag, input logic [479:0] got, input logic [479:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [479:0] exp_px(input logic [14:0] alive);
        logic [479:0] v = '0;
        for (int k = 0; k < 15; k++) v[k*32 +: 32] = alive[k] ? 32'(32 + 64 * k) : 32'd0;
        return v;
    endfunction

    function automatic logic [479:0] exp_py(input logic [14:0] alive);
        logic [479:0] v = '0;
        for (int k = 0; k < 15; k++) v[k*32 +: 32] = alive[k] ? 32'd30 : 32'd0;
        return v;
    endfunction

    task automatic model_reset();
        m_alive = '1;
        m_score = 0;
        m_over  = 1'b0;
        sb.delete();
    endtask

    task automatic do_reset();
        vblnk = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        step();
    endtask

    // One frame: latched at (x,y); player moves to (x2,y2) once the scan is underway
    task automatic run_frame(input int x, input int y, input int x2, input int y2);
        exp_t e;
        int   busy_cnt;
        bit   done;
        player_x = 11'(x);
        player_y = 11'(y);
        vblnk    = 1'b0;
        step();
        step();
        if (m_over) begin
            busy_cnt = 0;
            vblnk = 1'b1;
            for (int i = 0; i < 20; i++) begin
                step();
                if (scan_busy) busy_cnt++;
            end
            chk("over_no_scan", 480'(busy_cnt), 480'(0));
            vblnk = 1'b0;
            return;
        end
        e.hits = '0;
        for (int k = 0; k < 15; k++) begin
            if (m_alive[k] && absd(x, 32 + 64 * k) <= 8 && absd(y, 30) <= 8) begin
                m_alive[k] = 1'b0;
                e.hits[k]  = 1'b1;
                m_score    = (m_score + 10 > 65535) ? 65535 : m_score + 10;
            end
        end
        e.alive     = m_alive;
        e.score     = m_score;
        e.all_eaten = (m_alive == '0);
        m_over      = e.all_eaten;
        sb.push_back(e);

        vblnk    = 1'b1;
        busy_cnt = 0;
        done     = 1'b0;
        for (int cnt = 0; cnt < 40 && !done; cnt++) begin
            step();
            if (cnt == 1) begin
                player_x = 11'(x2);
                player_y = 11'(y2);
            end
            for (int k = 0; k < 15; k++) begin
                if (sb[0].hits[k] && cnt == k)     chk("alive_before_eval", 480'(dot_alive[k]), 480'(1));
                if (sb[0].hits[k] && cnt == k + 1) chk("cleared_on_eval", 480'(dot_alive[k]), 480'(0));
            end
            if (scan_busy) busy_cnt++;
            else if (busy_cnt > 0) done = 1'b1;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("scan_timeout", 480'(0), 480'(1));
        end else begin
            chk("busy_cycles", 480'(busy_cnt), 480'(15));
            chk("score",       480'(score), 480'(e.score));
            chk("alive",       480'(dot_alive), 480'(e.alive));
            chk("all_eaten",   480'(all_eaten), 480'(e.all_eaten));
            chk("position_x",  480'(pos_x), exp_px(e.alive));
            chk("position_y",  480'(pos_y), exp_py(e.alive));
        end
        vblnk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        // Reset, released while vblnk is already high
        do_reset();
        chk("rst_alive",  480'(dot_alive), 480'(15'h7fff));
        chk("rst_pos_x3", 480'(pos_x[3]), 480'(224));
        chk("rst_pos_y3", 480'(pos_y[3]), 480'(30));
        chk("rst_score",  480'(score), 480'(0));
        chk("rst_busy",   480'(scan_busy), 480'(0));
        chk("rst_eaten",  480'(all_eaten), 480'(0));
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (scan_busy) busy_cnt++;
        end
        chk("no_scan_vblnk_held", 480'(busy_cnt), 480'(0));

        // Single hit on pellet 2, then radius boundary on pellet 1
        run_frame(160, 30, 160, 30);
        do_reset();
        run_frame(104, 38, 104, 38);
        do_reset();
        run_frame(105, 30, 105, 30);

        // Player input changes during a scan are ignored
        do_reset();
        run_frame(700, 200, 352, 30);
        chk("latched_alive5", 480'(dot_alive[5]), 480'(1));
        run_frame(352, 30, 352, 30);

        // Eat the whole level, one pellet per frame
        do_reset();
        for (int k = 0; k < 15; k++) begin
            run_frame(32 + 64 * k, 30, 32 + 64 * k, 30);
            if (k == 2) chk("sat_below", 480'(s_score), 480'(30));
            if (k == 3) chk("sat_clamp", 480'(s_score), 480'(31));
        end
        chk("level_score", 480'(score), 480'(150));
        chk("level_eaten", 480'(all_eaten), 480'(1));
        chk("sat_final",   480'(s_score), 480'(31));
        run_frame(32, 30, 32, 30);

        // game_start from OVER
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        model_reset();
        chk("gs_over_eaten", 480'(all_eaten), 480'(0));
        chk("gs_over_alive", 480'(dot_alive), 480'(15'h7fff));
        chk("gs_over_score", 480'(score), 480'(0));

        // game_start mid-scan abandons the scan
        player_x = 11'd32;
        player_y = 11'd30;
        vblnk = 1'b0;
        step();
        step();
        vblnk = 1'b1;
        for (int cnt = 0; cnt <= 4; cnt++) step();
        chk("mid_score_before", 480'(score), 480'(10));
        game_start = 1'b1;
        step();
        game_start = 1'b0;
        chk("gs_mid_busy",  480'(scan_busy), 480'(0));
        chk("gs_mid_score", 480'(score), 480'(0));
        chk("gs_mid_alive", 480'(dot_alive), 480'(15'h7fff));
        chk("gs_mid_eaten", 480'(all_eaten), 480'(0));
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (scan_busy) busy_cnt++;
        end
        chk("gs_mid_abandoned", 480'(busy_cnt), 480'(0));

        // Asynchronous reset mid-scan, observed between clock edges
        vblnk = 1'b0;
        step();
        step();
        vblnk = 1'b1;
        for (int cnt = 0; cnt <= 3; cnt++) step();
        chk("async_pre_score", 480'(score), 480'(10));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy",  480'(scan_busy), 480'(0));
        chk("async_score", 480'(score), 480'(0));
        chk("async_alive", 480'(dot_alive), 480'(15'h7fff));
        chk("async_pos_x", 480'(pos_x), exp_px(15'h7fff));
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
